// File: rtl/microprogram_sequencer_pkg.sv
// Control-unit package shared by the microprogram sequencer and the
// next-state address selector.
// Contents:
//   SEL_*       2-bit next-address select codes driven on M
//   DEFAULT_AW  default microaddress width
package microprogram_sequencer_pkg;

   localparam int DEFAULT_AW = 8;

   localparam logic [1:0] SEL_ENCODER = 2'b00;
   localparam logic [1:0] SEL_CONST   = 2'b01;
   localparam logic [1:0] SEL_CR      = 2'b10;
   localparam logic [1:0] SEL_INC     = 2'b11;

endpackage

// File: rtl/microprogram_sequencer_next_address_mux.sv
// Combinational next-microaddress selector. It picks one of four sources
// with the select code. An encoder select without a recognised opcode is
// replaced by the trap address.
// Ports:
//   m           select code (SEL_* from the package)
//   enc_addr    encoder dispatch address
//   enc_valid   encoder recognised the opcode
//   cr_addr     address field of the current control word
//   state       current microaddress (incrementer source)
//   next_addr   selected next microaddress
//   dispatch_q  this select is a valid dispatch
//   trap_q      this select is an invalid dispatch (trap)
module next_address_mux
   import microprogram_sequencer_pkg::*;
#(
   parameter int              AW         = DEFAULT_AW,
   parameter logic [AW-1:0]   CONST_ADDR = {{(AW-1){1'b0}}, 1'b1},
   parameter logic [AW-1:0]   TRAP_ADDR  = '1
) (
   input  logic [1:0]    m,
   input  logic [AW-1:0] enc_addr,
   input  logic          enc_valid,
   input  logic [AW-1:0] cr_addr,
   input  logic [AW-1:0] state,
   output logic [AW-1:0] next_addr,
   output logic          dispatch_q,
   output logic          trap_q
);

   always_comb begin
      next_addr  = state;
      dispatch_q = 1'b0;
      trap_q     = 1'b0;
      unique case (m)
         SEL_ENCODER: begin
            dispatch_q = enc_valid;
            trap_q     = ~enc_valid;
            next_addr  = enc_valid ? enc_addr : TRAP_ADDR;
         end
         SEL_CONST: next_addr = CONST_ADDR;
         SEL_CR:    next_addr = cr_addr;
         // Wraps silently from all ones to zero.
         SEL_INC:   next_addr = state + {{(AW-1){1'b0}}, 1'b1};
         default:   next_addr = state;
      endcase
   end

endmodule

// File: rtl/microprogram_sequencer.sv
// Microprogram sequencer. It holds the current control-memory address and
// loads the next one every clock unless Hold is high. The dispatch and trap
// pulses are registered, so they line up with the State they describe.
// Ports:
//   Clk        rising-edge clock
//   Reset      asynchronous active-high reset
//   M          next-address select code
//   EncAddr    encoder dispatch address
//   EncValid   encoder recognised the opcode
//   CrAddr     control-word address field
//   Hold       freeze (memory wait)
//   State      current microaddress to the control ROM
//   Dispatch   one-cycle pulse after a valid encoder load
//   Trap       one-cycle pulse after a trap load
//   InstCount  valid dispatches since reset (wraps)
module microprogram_sequencer
   import microprogram_sequencer_pkg::*;
#(
   parameter int              AW         = DEFAULT_AW,
   parameter logic [AW-1:0]   RESET_ADDR = '0,
   parameter logic [AW-1:0]   CONST_ADDR = {{(AW-1){1'b0}}, 1'b1},
   parameter logic [AW-1:0]   TRAP_ADDR  = '1,
   parameter int              CW         = 16
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic [1:0]    M,
   input  logic [AW-1:0] EncAddr,
   input  logic          EncValid,
   input  logic [AW-1:0] CrAddr,
   input  logic          Hold,
   output logic [AW-1:0] State,
   output logic          Dispatch,
   output logic          Trap,
   output logic [CW-1:0] InstCount
);

   logic [AW-1:0] next_addr;
   logic          dispatch_q;
   logic          trap_q;

   next_address_mux #(
      .AW         (AW),
      .CONST_ADDR (CONST_ADDR),
      .TRAP_ADDR  (TRAP_ADDR)
   ) u_mux (
      .m          (M),
      .enc_addr   (EncAddr),
      .enc_valid  (EncValid),
      .cr_addr    (CrAddr),
      .state      (State),
      .next_addr  (next_addr),
      .dispatch_q (dispatch_q),
      .trap_q     (trap_q)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         State     <= RESET_ADDR;
         Dispatch  <= 1'b0;
         Trap      <= 1'b0;
         InstCount <= '0;
      end else if (Hold) begin
         // A held edge is not a load, so it must not re-announce a pulse.
         Dispatch  <= 1'b0;
         Trap      <= 1'b0;
      end else begin
         State     <= next_addr;
         Dispatch  <= dispatch_q;
         Trap      <= trap_q;
         if (dispatch_q)
            InstCount <= InstCount + {{(CW-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: doc/microprogram_sequencer.md
# microprogram_sequencer

Microprogram sequencer for the RISC control unit. It holds the current control-memory address (microaddress) and loads the next one on each clock, based on the 2-bit next-address select code from the next-state address selector. The candidate sources are:
- the instruction encoder's dispatch address,
- a fixed constant,
- the control register's address field,
- the incremented current address.

It sits between the next-state selector and the control-memory ROM, and closes the microcode loop.

## Interface
Parameters:
- AW, 8, microaddress width
- RESET_ADDR, 0, microaddress loaded on reset
- CONST_ADDR, 1, address selected by code 01
- TRAP_ADDR, 8'hFF (all ones at AW), address loaded on an invalid dispatch
- CW, 16, instruction counter width

Ports:
- Clk  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-high reset
- M  in  2  next-address select: 00 encoder, 01 constant, 10 control-register field, 11 incrementer
- EncAddr  in  AW  dispatch address from instruction encoder
- EncValid  in  1  encoder recognised the current opcode
- CrAddr  in  AW  address field of current control word
- Hold  in  1  freeze sequencer (memory wait / MOC not yet asserted)
- State  out  AW  current microaddress to control ROM
- Dispatch  out  1  high for one cycle after a valid encoder load
- Trap  out  1  high for one cycle after a trap load
- InstCount  out  CW  number of valid dispatches since reset

## Operation
- Next address (combinational, from current M):
  - 00: EncAddr if EncValid, else TRAP_ADDR
  - 01: CONST_ADDR
  - 10: CrAddr
  - 11: State+1, modulo 2^AW
- On each rising Clk with Hold=0:
  - State loads the next address.
  - Dispatch <= (M==00 && EncValid).
  - Trap <= (M==00 && !EncValid).
  - InstCount increments when Dispatch's next value is 1.
- Hold=1: State, InstCount unchanged; Dispatch and Trap forced to 0 on that edge. Hold overrides every M code.
- Reset asserted (any time, including mid-hold or mid-dispatch), immediately and asynchronously:
  - State=RESET_ADDR, Dispatch=0, Trap=0, InstCount=0.
- After Reset deasserts: first edge loads normally, based on M at that edge.
- Incrementer wrap: State=all ones with M=11 -> State=0. No flag.
- InstCount wraps from all ones to 0 silently.
- EncValid is ignored for M≠00. CrAddr and EncAddr are ignored unless selected.
- The block does not see Sts. Condition evaluation is entirely upstream in M.

## Timing
- One-cycle loop: State -> ROM -> control word (N, CrAddr) -> selector -> M -> State at the next edge. M, EncAddr, EncValid, CrAddr must be stable before the Clk edge. No internal pipelining.
- State latency: one edge from a select to the new address.
- Dispatch and Trap are registered. They appear in the same cycle the new State is presented. They are mutually exclusive.
- InstCount reflects a dispatch in the same cycle Dispatch is high.
- Reset values: State=RESET_ADDR, Dispatch=0, Trap=0, InstCount=0.

## Structure
- Shared package (control-unit package, common with the next-state selector):
  - select-code constants: SEL_ENCODER=2'b00, SEL_CONST=2'b01, SEL_CR=2'b10, SEL_INC=2'b11
  - default AW
- Sub-module next_address_mux: purely combinational 4:1 select plus trap substitution. It outputs the next address and the dispatch/trap qualifiers.
- Top level holds the State register, the pulse flops and InstCount.

## Test plan
- Reset mid-operation: drive M=11 from State=5, assert Reset between edges -> State=0, InstCount=0 immediately, before the next edge.
- Increment and wrap (AW=8): State=8'hFE, M=11 for two edges -> 8'hFF then 8'h00. Dispatch and Trap stay 0.
- Valid dispatch: M=00, EncAddr=8'h3C, EncValid=1 -> next cycle State=8'h3C, Dispatch=1 for exactly one cycle, InstCount 0->1.
- Invalid dispatch: M=00, EncValid=0, EncAddr=8'h3C -> State=8'hFF, Trap=1 for one cycle, InstCount unchanged.
- Constant and CR: M=01 -> State=8'h01; then M=10, CrAddr=8'h47 -> State=8'h47.
- Hold: State=8'h10, M=00 valid, Hold=1 for 3 edges -> State stays 8'h10, Dispatch=0. Release Hold -> State=EncAddr, Dispatch=1 once.
